// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, FSM state encoding and operand-pair layout for the MAC feeder
package mac_pkg;
  localparam int OPW = 4;
  localparam int ACCW = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } pair_t;
endpackage

// File: rtl/mac_operand_buffer.sv
// mac_operand_buffer: DEPTH x {a,b} register file, one write port, async read port, no reset
module mac_operand_buffer
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*OPW-1:0]  wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*OPW-1:0]  rdata
);
  logic [2*OPW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers operand pairs and streams them into the MAC as a dot-product run
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [OPW-1:0]  load_a,
  input  logic [OPW-1:0]  load_b,
  input  logic            start,
  output logic            busy,
  output logic            mac_en,
  output logic            mac_clr,
  output logic [OPW-1:0]  mac_a,
  output logic [OPW-1:0]  mac_b,
  input  logic [ACCW-1:0] mac_acc,
  output logic [ACCW-1:0] result,
  output logic            result_valid
);
  logic [2:0] state, nxt;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr, rd_nxt;
  logic we, last;
  pair_t rd_pair;
  assign busy = state != S_IDLE;
  assign load_ready = state == S_IDLE && count < (AW+1)'(DEPTH) && !start;
  assign we = load_valid && load_ready;
  assign last = {1'b0, rd_ptr} == count - (AW+1)'(1);
  mac_operand_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .we(we),
    .waddr(count[AW-1:0]),
    .wdata({load_a, load_b}),
    .raddr(rd_nxt),
    .rdata(rd_pair)
  );
  always_comb begin
    nxt = state == S_IDLE  ? ((start && count != '0) ? S_CLEAR : S_IDLE) :
          state == S_CLEAR ? S_RUN :
          state == S_RUN   ? (last ? S_DRAIN : S_RUN) :
          state == S_DRAIN ? S_DONE : S_IDLE;
    rd_nxt = state == S_RUN ? rd_ptr + AW'(1) : '0;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      rd_ptr <= '0;
      mac_clr <= 1'b0;
      mac_en <= 1'b0;
      mac_a <= '0;
      mac_b <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= nxt;
      count <= state == S_DONE ? '0 : count + (AW+1)'(we);
      rd_ptr <= rd_nxt;
      mac_clr <= nxt == S_CLEAR;
      mac_en <= nxt == S_RUN;
      mac_a <= nxt == S_RUN ? rd_pair.a : '0;
      mac_b <= nxt == S_RUN ? rd_pair.b : '0;
      result_valid <= nxt == S_DONE;
      if (nxt == S_DONE) result <= mac_acc;
    end
endmodule
